alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction issue controller sitting directly upstream of the ALU/register-file stage. Accepts 16-bit instruction words over a valid/ready handshake into a one-entry holding buffer, decodes them, and drives the read addresses, ALU opcode and write-enable of the ALU/register-file stage. Captures the ALU flag word into a program status register. Supports optional Z-conditional execution and counts retired instructions.

## Interface
- Z_BIT, 6: bit index of the Z flag within `flagreg`/`psr`
- CNT_W, 16: width of the retired-instruction counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- instr_valid  input  1  upstream word valid
- instr  input  16  instruction: [15:12] op, [11:7] ra1 (src1/dest), [6:2] ra2, [1] wb, [0] cond
- instr_ready  output  1  buffer can accept; equals !buf_full
- flagreg  input  16  flag word from ALU (combinational)
- ra1  output  5  register read address 1 / write destination
- ra2  output  5  register read address 2
- inst  output  4  ALU opcode
- regwrite  output  1  register-file write enable
- psr  output  16  captured flag word
- retired  output  CNT_W  retired-instruction count
- busy  output  1  state != IDLE or buf_full

## Operation
- Reset (async, rst_n low): state IDLE, buf_full 0, ra1/ra2/inst/regwrite/psr/retired all 0; instr_ready 1, busy 0.
- Accept: instr_valid && instr_ready at an edge loads `buf`, sets buf_full. Accept is legal in any state.
- States: IDLE, ISSUE, WB.
- IDLE: if buf_full → load ra1/ra2/inst and internal wb/cond from buf, clear buf_full, go ISSUE (subject to cond rule).
- ISSUE: regwrite 0; ALU computes on ra1/ra2/inst. On edge: psr <= flagreg; regwrite <= wb; go WB.
- WB: regwrite = latched wb; ra1/ra2/inst held stable. On edge: regwrite <= 0; retired increments; if buf_full issue next instruction directly (go ISSUE, load from buf), else go IDLE.
- Cond rule: at the issue edge, if cond=1 and psr[Z_BIT]=0, the instruction is discarded: buf_full cleared, ra1/ra2/inst unchanged, no ISSUE/WB, retired unchanged, state goes/stays IDLE.
- Simultaneous accept and drain at one edge: buf reloads with the new word, buf_full stays 1.
- retired wraps from all-ones to 0.
- Instructions with wb=0 still update psr and count as retired.

## Timing
- Word accepted at edge E0 from IDLE: outputs valid after E1 (ISSUE), regwrite high after E2 (WB), register file writes at E3.
- Back-to-back throughput: one instruction per 2 cycles (ISSUE, WB alternating), instr_ready high except while a word waits in buf.
- psr reflects an instruction's flags from the edge ending its ISSUE cycle; a following cond instruction issued at the WB→ISSUE edge sees that value.
- regwrite is high for exactly one cycle per executed wb=1 instruction, never two consecutive cycles.
- Reset mid-operation: all state cleared immediately; a pending buffered word and any in-flight write are dropped (regwrite falls asynchronously).

## Configuration
- ALU_ISSUE_COND_EXEC_EN defined: cond bit honoured per the cond rule.
- Undefined: instr[0] ignored; every accepted instruction executes; psr still captured.

## Test plan
- Single op: instr=0x1 op, ra1=3, ra2=4, wb=1 accepted at E0 → ra1=3/ra2=4/inst=1 after E1, regwrite=1 only during cycle after E2, retired=1 after E3.
- Back-to-back: instr_valid held high with 4 words → regwrite pulses every 2 cycles, retired=4, no word lost, instr_ready low only while buf holds a word.
- Cond skip (macro defined): prior op leaves psr[6]=0, then cond=1 word → no regwrite, retired unchanged, ra1/ra2/inst unchanged; with psr[6]=1 it executes. Macro undefined: executes in both cases.
- wb=0 word: psr updated, retired+1, regwrite stays 0.
- Reset asserted during WB with buf_full=1 → all outputs 0, instr_ready=1, busy=0 immediately; nothing executes after release until a new accept.
- retired preloaded via 2^CNT_W executed instructions (CNT_W=4 build) → wraps to 0 on the 16th.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller feeding the ALU/register-file stage: one-entry instruction buffer,
// IDLE/ISSUE/WB sequencing, PSR capture and retired count. Define ALU_ISSUE_COND_EXEC_EN
// to make instr[0] skip the instruction when psr[Z_BIT] is clear.
module alu_issue_ctrl #(
  parameter int unsigned Z_BIT = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  input  logic [15:0]      flagreg,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  output logic [3:0]       inst,
  output logic             regwrite,
  output logic [15:0]      psr,
  output logic [CNT_W-1:0] retired,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

  state_e           state_q, state_d;
  logic [15:0]      instr_buf_q, instr_buf_d;
  logic             buf_full_q, buf_full_d;
  logic [4:0]       ra1_q, ra1_d;
  logic [4:0]       ra2_q, ra2_d;
  logic [3:0]       inst_q, inst_d;
  logic             wb_q, wb_d;
  logic             regwrite_q, regwrite_d;
  logic [15:0]      psr_q, psr_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic accept;
  logic issue_slot;
  logic cond_skip;
  logic issue_go;

  // A buffered word may leave the buffer only from IDLE or at the end of WB.
  always_comb begin
    accept     = instr_valid && !buf_full_q;
    issue_slot = buf_full_q && ((state_q == StIdle) || (state_q == StWb));
  end

`ifdef ALU_ISSUE_COND_EXEC_EN
  always_comb begin
    cond_skip = instr_buf_q[0] && !psr_q[Z_BIT];
  end
`else
  logic unused_cond;
  always_comb begin
    cond_skip   = 1'b0;
    unused_cond = instr_buf_q[0] ^ psr_q[Z_BIT];
  end
`endif

  always_comb begin
    issue_go = issue_slot && !cond_skip;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = issue_go ? StIssue : StIdle;
      StIssue: state_d = StWb;
      StWb:    state_d = issue_go ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: buffer, decoded fields, PSR, write strobe and counter
  always_comb begin
    instr_buf_d = instr_buf_q;
    buf_full_d  = buf_full_q;
    ra1_d       = ra1_q;
    ra2_d       = ra2_q;
    inst_d      = inst_q;
    wb_d        = wb_q;
    regwrite_d  = 1'b0;
    psr_d       = psr_q;
    retired_d   = retired_q;

    // Skipped words are drained too, so issue_slot alone clears the buffer.
    if (issue_slot) begin
      buf_full_d = 1'b0;
    end
    if (accept) begin
      instr_buf_d = instr;
      buf_full_d  = 1'b1;
    end

    if (issue_go) begin
      inst_d = instr_buf_q[15:12];
      ra1_d  = instr_buf_q[11:7];
      ra2_d  = instr_buf_q[6:2];
      wb_d   = instr_buf_q[1];
    end

    if (state_q == StIssue) begin
      psr_d      = flagreg;
      regwrite_d = wb_q;
    end

    if (state_q == StWb) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_buf_q <= '0;
      buf_full_q  <= 1'b0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      inst_q      <= '0;
      wb_q        <= 1'b0;
      regwrite_q  <= 1'b0;
      psr_q       <= '0;
      retired_q   <= '0;
    end else begin
      instr_buf_q <= instr_buf_d;
      buf_full_q  <= buf_full_d;
      ra1_q       <= ra1_d;
      ra2_q       <= ra2_d;
      inst_q      <= inst_d;
      wb_q        <= wb_d;
      regwrite_q  <= regwrite_d;
      psr_q       <= psr_d;
      retired_q   <= retired_d;
    end
  end

  // Outputs
  always_comb begin
    instr_ready = !buf_full_q;
    busy        = (state_q != StIdle) || buf_full_q;
    ra1         = ra1_q;
    ra2         = ra2_q;
    inst        = inst_q;
    regwrite    = regwrite_q;
    psr         = psr_q;
    retired     = retired_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: table of single-instruction vectors plus
// back-to-back, reset-in-WB and counter-wrap sequences (CNT_W = 4).
module tb_alu_issue_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [15:0]      instr = '0;
  logic             instr_ready;
  logic [15:0]      flagreg = '0;
  logic [4:0]       ra1, ra2;
  logic [3:0]       inst;
  logic             regwrite;
  logic [15:0]      psr;
  logic [CNT_W-1:0] retired;
  logic             busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.Z_BIT(6), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .flagreg    (flagreg),
    .ra1        (ra1),
    .ra2        (ra2),
    .inst       (inst),
    .regwrite   (regwrite),
    .psr        (psr),
    .retired    (retired),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] flag;
    bit          exec;
    logic [4:0]  e_ra1;
    logic [4:0]  e_ra2;
    logic [3:0]  e_inst;
    logic        e_rw;
    logic [15:0] e_psr;
  } vec_t;

  vec_t vecs[6];
  logic [CNT_W-1:0] exp_ret;

  function automatic logic [15:0] mkword(input int k);
    logic [15:0] w;
    w = {4'(k), 5'(k + 1), 5'(k + 2), 1'b1, 1'b0};
    return w;
  endfunction

  task automatic run_stream(input int n, output int pulses, output int consec,
                            output int low_cnt, output int done);
    int   k;
    int   cycles;
    logic prev_rw;
    logic accepted;
    k = 0; cycles = 0; prev_rw = 1'b0;
    pulses = 0; consec = 0; low_cnt = 0;
    while ((k < n || busy) && cycles < 20 * n + 20) begin
      @(negedge clk);
      if (regwrite) begin
        pulses++;
        if (prev_rw) consec++;
      end
      prev_rw = regwrite;
      if (!instr_ready) low_cnt++;
      instr_valid = (k < n);
      instr       = mkword(k);
      accepted    = instr_valid && instr_ready;
      @(posedge clk);
      #1;
      if (accepted) k++;
      cycles++;
    end
    instr_valid = 1'b0;
    done = (k == n && !busy) ? 1 : 0;
  endtask

  initial begin
    int pulses, consec, low_cnt, done;

    vecs[0] = '{16'h1192, 16'h0000, 1'b1, 5'd3, 5'd4, 4'd1, 1'b1, 16'h0000};
`ifdef ALU_ISSUE_COND_EXEC_EN
    vecs[1] = '{16'h229B, 16'h0040, 1'b0, 5'd3, 5'd4, 4'd1, 1'b0, 16'h0000};
`else
    vecs[1] = '{16'h229B, 16'h0040, 1'b1, 5'd5, 5'd6, 4'd2, 1'b1, 16'h0040};
`endif
    vecs[2] = '{16'h33A0, 16'h0040, 1'b1, 5'd7, 5'd8, 4'd3, 1'b0, 16'h0040};
    vecs[3] = '{16'h44AB, 16'h1234, 1'b1, 5'd9, 5'd10, 4'd4, 1'b1, 16'h1234};
`ifdef ALU_ISSUE_COND_EXEC_EN
    vecs[4] = '{16'h55B3, 16'hFFFF, 1'b0, 5'd9, 5'd10, 4'd4, 1'b0, 16'h1234};
`else
    vecs[4] = '{16'h55B3, 16'hFFFF, 1'b1, 5'd11, 5'd12, 4'd5, 1'b1, 16'hFFFF};
`endif
    vecs[5] = '{16'hFFFE, 16'h0040, 1'b1, 5'd31, 5'd31, 4'd15, 1'b1, 16'h0040};

    // Reset state
    #1;
    check("rst_ra1", ra1, 0);
    check("rst_ra2", ra2, 0);
    check("rst_inst", inst, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_psr", psr, 0);
    check("rst_retired", retired, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      flagreg     = vecs[i].flag;
      instr       = vecs[i].word;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ready_low", i), instr_ready, 0);
      check($sformatf("v%0d_busy", i), busy, 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_ra1", i), ra1, vecs[i].e_ra1);
      check($sformatf("v%0d_ra2", i), ra2, vecs[i].e_ra2);
      check($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
      check($sformatf("v%0d_rw_issue", i), regwrite, 0);
      if (vecs[i].exec) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_rw_wb", i), regwrite, vecs[i].e_rw);
        check($sformatf("v%0d_psr", i), psr, vecs[i].e_psr);
        @(posedge clk);
        @(negedge clk);
        exp_ret = exp_ret + 1'b1;
        check($sformatf("v%0d_rw_after", i), regwrite, 0);
        check($sformatf("v%0d_retired", i), retired, exp_ret);
        check($sformatf("v%0d_idle", i), busy, 0);
      end else begin
        check($sformatf("v%0d_skip_busy", i), busy, 0);
        check($sformatf("v%0d_skip_psr", i), psr, vecs[i].e_psr);
        check($sformatf("v%0d_skip_retired", i), retired, exp_ret);
      end
    end

    // Back-to-back: four words with instr_valid held high
    run_stream(4, pulses, consec, low_cnt, done);
    exp_ret = exp_ret + 4'd4;
    check("b2b_done", done, 1);
    check("b2b_pulses", pulses, 4);
    check("b2b_consec", consec, 0);
    check("b2b_ready_low", low_cnt, 4);
    check("b2b_retired", retired, exp_ret);
    check("b2b_last_ra1", ra1, 5'd4);
    check("b2b_last_inst", inst, 4'd3);

    // Reset while in WB with a second word waiting in the buffer
    @(negedge clk);
    instr       = mkword(7);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = mkword(8);
    @(posedge clk);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("rwb_pre_regwrite", regwrite, 1);
    check("rwb_pre_ready", instr_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rwb_regwrite", regwrite, 0);
    check("rwb_ra1", ra1, 0);
    check("rwb_inst", inst, 0);
    check("rwb_psr", psr, 0);
    check("rwb_retired", retired, 0);
    check("rwb_ready", instr_ready, 1);
    check("rwb_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rwb_post%0d_rw", c), regwrite, 0);
      check($sformatf("rwb_post%0d_busy", c), busy, 0);
    end
    check("rwb_post_retired", retired, 0);

    // Sixteen executed instructions wrap the 4-bit counter back to zero
    run_stream(16, pulses, consec, low_cnt, done);
    check("wrap_done", done, 1);
    check("wrap_pulses", pulses, 16);
    check("wrap_consec", consec, 0);
    check("wrap_retired", retired, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
